// File: rtl/mips_pkg.sv
// mips_pkg: shared reset vector and fetch state encoding
package mips_pkg;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  typedef enum logic [2:0] {IDLE, WAIT_ADDR, WAIT_DATA, HOLD, DISCARD} fetch_state_t;
endpackage

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: single-outstanding instruction fetch sequencer with flush discard
// Optional misaligned-PC fetch exception enabled by defining IF_ADDR_EXC_EN.
module inst_fetch_ctrl #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             pc_ce_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             stallF_o,
  output logic [WIDTH-1:0] instF_o,
  output logic             instF_valid_o,
  output logic             instF_exc_o
);
  import mips_pkg::*;
  fetch_state_t state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d, buf_q, buf_d;
  logic drop_q, drop_d, misal;
`ifdef IF_ADDR_EXC_EN
  logic exc_q;
  assign misal = pc_i[1:0] != 2'b00;
  assign instF_exc_o = state_q == HOLD && exc_q && !flush_i;
  // HOLD is only entered straight from IDLE for a misaligned PC
  always_ff @(posedge clk)
    exc_q <= resetn && state_d == HOLD && (state_q == HOLD ? exc_q : state_q == IDLE);
`else
  assign misal = 1'b0;
  assign instF_exc_o = 1'b0;
`endif
  assign inst_req = state_q == WAIT_ADDR;
  assign inst_addr = addr_q;
  assign stallF_o = !(flush_i || (state_q == WAIT_DATA && inst_data_ok && !stall_i) ||
                      (state_q == HOLD && !stall_i));
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    buf_d = buf_q;
    drop_d = drop_q;
    instF_o = inst_rdata;
    instF_valid_o = 1'b0;
    case (state_q)
      IDLE: if (pc_ce_i && !flush_i) begin
        if (misal) begin
          buf_d = '0;
          state_d = HOLD;
        end else begin
          addr_d = pc_i;
          state_d = WAIT_ADDR;
        end
      end
      WAIT_ADDR: if (inst_addr_ok) begin
        state_d = (flush_i || drop_q) ? DISCARD : WAIT_DATA;
        drop_d = 1'b0;
      end else if (flush_i) drop_d = 1'b1;
      WAIT_DATA: if (inst_data_ok) begin
        instF_valid_o = !flush_i;
        buf_d = inst_rdata;
        state_d = (flush_i || !stall_i) ? IDLE : HOLD;
      end else if (flush_i) state_d = DISCARD;
      HOLD: begin
        instF_o = buf_q;
        instF_valid_o = !flush_i;
        state_d = (flush_i || !stall_i) ? IDLE : HOLD;
      end
      DISCARD: state_d = inst_data_ok ? IDLE : DISCARD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      state_q <= IDLE;
      addr_q <= RESET_PC;
      buf_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      buf_q <= buf_d;
      drop_q <= drop_d;
    end
  // data_ok with nothing awaiting data is a bus protocol violation
  assert property (@(posedge clk) disable iff (!resetn)
    !(inst_data_ok && (state_q == IDLE || state_q == WAIT_ADDR)));
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed stimulus with queue scoreboard for bus addresses and deliveries
module tb_inst_fetch_ctrl;
  localparam int W = 32;
  logic clk = 0, resetn = 0, pc_ce_i = 0, stall_i = 0, flush_i = 0;
  logic inst_addr_ok = 0, inst_data_ok = 0;
  logic [W-1:0] pc_i = 32'hbfc00000, inst_rdata = 0;
  logic inst_req, stallF_o, instF_valid_o, instF_exc_o;
  logic [W-1:0] inst_addr, instF_o;
  int checks = 0, errors = 0;
  logic [W-1:0] aq[$];
  logic [W:0] dq[$];
  inst_fetch_ctrl dut (
    .clk(clk), .resetn(resetn), .pc_i(pc_i), .pc_ce_i(pc_ce_i), .stall_i(stall_i),
    .flush_i(flush_i), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .stallF_o(stallF_o), .instF_o(instF_o), .instF_valid_o(instF_valid_o),
    .instF_exc_o(instF_exc_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Monitor: accepted bus addresses and accepted deliveries are popped and compared
  always @(negedge clk) if (resetn) begin
    if (inst_req && inst_addr_ok) begin
      if (aq.size() == 0) chk("unexpected_issue", {1'b0, inst_addr}, 33'h1ffffffff);
      else chk("issue_addr", {1'b0, inst_addr}, {1'b0, aq.pop_front()});
    end
    if (instF_valid_o && !stall_i) begin
      if (dq.size() == 0) chk("unexpected_delivery", {instF_exc_o, instF_o}, 33'h1ffffffff);
      else chk("delivery", {instF_exc_o, instF_o}, dq.pop_front());
    end
  end
  initial begin
    pc_ce_i = 1;
    step(); step();
    chk("rst_req", inst_req, 0);
    chk("rst_valid", instF_valid_o, 0);
    chk("rst_stallF", stallF_o, 1);
    chk("rst_addr", inst_addr, 32'hbfc00000);
    // test 1: basic fetch
    resetn = 1; aq.push_back(32'hbfc00000); dq.push_back({1'b0, 32'h24080001});
    step(); inst_addr_ok = 1; #1;
    chk("t1_req", inst_req, 1);
    chk("t1_addr", inst_addr, 32'hbfc00000);
    step(); inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h24080001; #1;
    chk("t1_valid", instF_valid_o, 1);
    chk("t1_inst", instF_o, 32'h24080001);
    chk("t1_stallF", stallF_o, 0);
    step(); inst_data_ok = 0; pc_i = 32'hbfc00004; aq.push_back(32'hbfc00004); #1;
    chk("t1_idle_stallF", stallF_o, 1);
    chk("t1_idle_req", inst_req, 0);
    // test 2: stalled delivery held for 3 cycles
    step(); inst_addr_ok = 1;
    step(); inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h8c090004; stall_i = 1;
    dq.push_back({1'b0, 32'h8c090004}); #1;
    chk("t2_valid_stalled", instF_valid_o, 1);
    chk("t2_stallF0", stallF_o, 1);
    for (int i = 1; i < 3; i++) begin
      step(); inst_data_ok = 0; inst_rdata = 32'hdeadbeef; #1;
      chk("t2_hold_inst", instF_o, 32'h8c090004);
      chk("t2_hold_stallF", stallF_o, 1);
    end
    step(); stall_i = 0; #1;
    chk("t2_release_stallF", stallF_o, 0);
    chk("t2_release_inst", instF_o, 32'h8c090004);
    step(); pc_i = 32'hbfc00008; aq.push_back(32'hbfc00008);
    step(); inst_addr_ok = 1; #1;
    chk("t2_next_req", inst_req, 1);
    // test 3: flush in WAIT_DATA
    step(); inst_addr_ok = 0; flush_i = 1; pc_i = 32'hbfc00100; #1;
    chk("t3_flush_valid", instF_valid_o, 0);
    chk("t3_flush_stallF", stallF_o, 0);
    step(); flush_i = 0; #1;
    chk("t3_discard_stallF", stallF_o, 1);
    step(); inst_data_ok = 1; inst_rdata = 32'h11111111; #1;
    chk("t3_drop_valid", instF_valid_o, 0);
    step(); inst_data_ok = 0; aq.push_back(32'hbfc00100);
    // test 4: flush in WAIT_ADDR, addr_ok 3 cycles later
    step(); flush_i = 1; pc_i = 32'hbfc00200; #1;
    chk("t4_req", inst_req, 1);
    chk("t4_addr", inst_addr, 32'hbfc00100);
    for (int i = 0; i < 2; i++) begin
      step(); flush_i = 0; #1;
      chk("t4_req_held", inst_req, 1);
      chk("t4_addr_held", inst_addr, 32'hbfc00100);
    end
    step(); inst_addr_ok = 1;
    step(); inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h22222222; #1;
    chk("t4_drop_valid", instF_valid_o, 0);
    chk("t4_drop_req", inst_req, 0);
    // test 5: reset during WAIT_DATA
    step(); inst_data_ok = 0; aq.push_back(32'hbfc00200);
    step(); inst_addr_ok = 1;
    step(); inst_addr_ok = 0; resetn = 0; pc_ce_i = 0;
    step(); #1;
    chk("t5_req", inst_req, 0);
    chk("t5_valid", instF_valid_o, 0);
    chk("t5_stallF", stallF_o, 1);
    chk("t5_addr", inst_addr, 32'hbfc00000);
    resetn = 1; pc_ce_i = 1; pc_i = 32'hbfc00002;
`ifdef IF_ADDR_EXC_EN
    dq.push_back({1'b1, 32'h0});
    step(); pc_ce_i = 0; #1;
    chk("t6_req", inst_req, 0);
    chk("t6_valid", instF_valid_o, 1);
    chk("t6_exc", instF_exc_o, 1);
    step(); #1;
    chk("t6_valid_after", instF_valid_o, 0);
    chk("t6_exc_after", instF_exc_o, 0);
`else
    aq.push_back(32'hbfc00002); dq.push_back({1'b0, 32'h44444444});
    step(); pc_ce_i = 0; inst_addr_ok = 1; #1;
    chk("t6_misaligned_addr", inst_addr, 32'hbfc00002);
    step(); inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h44444444; #1;
    chk("t6_exc_tied", instF_exc_o, 0);
    step(); inst_data_ok = 0;
`endif
    step(); step();
    chk("addr_queue_drained", aq.size(), 0);
    chk("data_queue_drained", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
